// File: rtl/cfg_pkg.sv
// cfg_pkg: shared FSM encoding, marker constants and default parameters for cfg_seq.
package cfg_pkg;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_REG_W      = 8;
  localparam int DEF_DAT_W      = 8;
  localparam int DEF_DELAY_UNIT = 1000;
  // Marker encodings at default widths; the sequencer tests the generic all-ones form.
  localparam logic [DEF_REG_W+DEF_DAT_W-1:0] END_MARK  = '1;
  localparam logic [DEF_REG_W-1:0]           DELAY_REG = '1;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_DONE,
    S_DELAY,
    S_DONE
  } state_t;
endpackage

// File: rtl/cfg_delay_timer.sv
// cfg_delay_timer: loadable down-counter that parks at zero and flags it.
module cfg_delay_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);
  logic [W-1:0] cnt;
  assign o_zero = cnt == '0;
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) cnt <= '0;
    else if (i_load) cnt <= i_val;
    else if (i_en && !o_zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/cfg_seq.sv
// cfg_seq: walks a {reg, data} ROM, issuing SCCB register writes and timed delays.
module cfg_seq
  import cfg_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int DAT_W       = DEF_DAT_W,
  parameter int DELAY_UNIT  = DEF_DELAY_UNIT,
  parameter int MAX_ENTRIES = 2**ADDR_W
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [REG_W+DAT_W-1:0] i_rom_data,
  output logic               o_wr_valid,
  input  logic               i_wr_ready,
  output logic [REG_W-1:0]   o_wr_reg,
  output logic [DAT_W-1:0]   o_wr_data,
  input  logic               i_wr_done,
  output logic               o_busy,
  output logic               o_done,
  output logic [ADDR_W:0]    o_count
);
  localparam int CNT_W = $clog2((2**DAT_W-1)*DELAY_UNIT+1);
  state_t state, state_n, adv_state;
  logic [ADDR_W-1:0] addr_n, adv_addr;
  logic [ADDR_W:0]   count_n;
  logic [REG_W-1:0]  reg_n, rom_reg;
  logic [DAT_W-1:0]  dat_n, rom_dat;
  logic              last, t_load, t_zero;
  logic [CNT_W-1:0]  t_val;
  assign {rom_reg, rom_dat} = i_rom_data;
  assign last      = o_rom_addr == ADDR_W'(MAX_ENTRIES-1);
  assign adv_state = last ? S_DONE : S_FETCH;
  assign adv_addr  = last ? o_rom_addr : o_rom_addr + 1'b1;
  // Timer holds N-1 so the DELAY state lasts exactly data*DELAY_UNIT cycles.
  assign t_val      = CNT_W'(rom_dat) * CNT_W'(DELAY_UNIT) - CNT_W'(1);
  assign o_wr_valid = state == S_ISSUE;
  assign o_busy     = state != S_IDLE;
  assign o_done     = state == S_DONE;
  cfg_delay_timer #(.W(CNT_W)) u_timer (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_load (t_load),
    .i_en   (state == S_DELAY),
    .i_val  (t_val),
    .o_zero (t_zero)
  );
  always_comb begin
    state_n = state;
    addr_n  = o_rom_addr;
    count_n = o_count;
    reg_n   = o_wr_reg;
    dat_n   = o_wr_data;
    t_load  = 1'b0;
    case (state)
      S_IDLE: if (i_start) begin
        addr_n  = '0;
        count_n = '0;
        state_n = S_FETCH;
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE:
        if (&rom_reg && &rom_dat) state_n = S_DONE;
        else if (&rom_reg && rom_dat == '0) begin
          addr_n  = adv_addr;
          state_n = adv_state;
        end else if (&rom_reg) begin
          t_load  = 1'b1;
          state_n = S_DELAY;
        end else begin
          reg_n   = rom_reg;
          dat_n   = rom_dat;
          state_n = S_ISSUE;
        end
      S_ISSUE: state_n = i_wr_ready ? S_WAIT_DONE : S_ISSUE;
      S_WAIT_DONE: if (i_wr_done) begin
        count_n = o_count + 1'b1;
        addr_n  = adv_addr;
        state_n = adv_state;
      end
      S_DELAY: if (t_zero) begin
        addr_n  = adv_addr;
        state_n = adv_state;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      state      <= S_IDLE;
      o_rom_addr <= '0;
      o_count    <= '0;
      o_wr_reg   <= '0;
      o_wr_data  <= '0;
    end else begin
      state      <= state_n;
      o_rom_addr <= addr_n;
      o_count    <= count_n;
      o_wr_reg   <= reg_n;
      o_wr_data  <= dat_n;
    end
endmodule

// File: tb/tb_cfg_seq.sv
// tb_cfg_seq: directed bench for cfg_seq with a registered ROM model and an SCCB responder.
module tb_cfg_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;
  logic        start_a = 1'b0, ready_a = 1'b0, spur_a = 1'b0, resp_a = 1'b0;
  logic        valid_a, busy_a, done_a, wr_done_a;
  logic [7:0]  addr_a, reg_a, dat_a;
  logic [8:0]  cnt_a;
  logic [15:0] data_a;
  logic [15:0] rom_a [256];
  assign wr_done_a = resp_a | spur_a;
  always @(posedge clk) data_a <= rom_a[addr_a];
  cfg_seq #(.ADDR_W(8), .DELAY_UNIT(4)) dut_a (
    .i_clk(clk), .i_rstn(rst_n), .i_start(start_a), .o_rom_addr(addr_a),
    .i_rom_data(data_a), .o_wr_valid(valid_a), .i_wr_ready(ready_a),
    .o_wr_reg(reg_a), .o_wr_data(dat_a), .i_wr_done(wr_done_a),
    .o_busy(busy_a), .o_done(done_a), .o_count(cnt_a)
  );
  logic        start_b = 1'b0, ready_b = 1'b1, resp_b = 1'b0;
  logic        valid_b, busy_b, done_b;
  logic [2:0]  addr_b;
  logic [7:0]  reg_b, dat_b;
  logic [3:0]  cnt_b;
  logic [15:0] data_b;
  logic [15:0] rom_b [8];
  always @(posedge clk) data_b <= rom_b[addr_b];
  cfg_seq #(.ADDR_W(3), .DELAY_UNIT(1)) dut_b (
    .i_clk(clk), .i_rstn(rst_n), .i_start(start_b), .o_rom_addr(addr_b),
    .i_rom_data(data_b), .o_wr_valid(valid_b), .i_wr_ready(ready_b),
    .o_wr_reg(reg_b), .o_wr_data(dat_b), .i_wr_done(resp_b),
    .o_busy(busy_b), .o_done(done_b), .o_count(cnt_b)
  );
  // SCCB responders: done pulse sampled on the second rising edge after accept.
  initial forever begin
    @(negedge clk); #1;
    if (valid_a && ready_a) begin
      @(posedge clk); @(posedge clk); #1 resp_a = 1'b1;
      @(posedge clk); #1 resp_a = 1'b0;
    end
  end
  initial forever begin
    @(negedge clk); #1;
    if (valid_b && ready_b) begin
      @(posedge clk); @(posedge clk); #1 resp_b = 1'b1;
      @(posedge clk); #1 resp_b = 1'b0;
    end
  end
  int done_cnt_a = 0, done_cnt_b = 0, wr_cnt_b = 0;
  logic wrap_b = 1'b0, prev_valid_b = 1'b0;
  logic [2:0] prev_addr_b = 3'd0;
  always @(negedge clk) begin
    done_cnt_a   <= done_cnt_a + int'(done_a);
    done_cnt_b   <= done_cnt_b + int'(done_b);
    prev_valid_b <= valid_b;
    prev_addr_b  <= addr_b;
    if (valid_b && !prev_valid_b) wr_cnt_b <= wr_cnt_b + 1;
    if (busy_b && prev_addr_b == 3'd7 && addr_b == 3'd0) wrap_b <= 1'b1;
  end
  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_a();
    start_a = 1'b1; tick(1); start_a = 1'b0;
  endtask
  task automatic wait_valid_a(output int n);
    n = 0;
    do begin tick(1); n++; end while (!valid_a && n < 3000);
  endtask
  task automatic wait_gap_a(output int n);
    n = 0;
    do begin tick(1); n++; end while (valid_a && n < 3000);
    do begin tick(1); n++; end while (!valid_a && n < 3000);
  endtask
  task automatic wait_done_a(output int n);
    n = 0;
    do begin tick(1); n++; end while (!done_a && n < 3000);
  endtask
  int n, d0;
  logic stable;
  initial begin
    foreach (rom_a[i]) rom_a[i] = 16'hFFFF;
    foreach (rom_b[i]) rom_b[i] = {8'(i + 1), 8'(i * 3)};
    tick(3);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_addr", addr_a, 0);
    chk("rst_count", cnt_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_regdat", {reg_a, dat_a}, 0);
    rst_n = 1'b1;
    tick(2);
    // Write, 960-cycle delay, write, end.
    rom_a[0] = 16'h1280; rom_a[1] = 16'hFFF0; rom_a[2] = 16'h1204; rom_a[3] = 16'hFFFF;
    ready_a = 1'b1;
    d0 = done_cnt_a;
    pulse_a();
    wait_valid_a(n);
    chk("s1_latency", 1 + n, 3);
    chk("s1_wr1", {reg_a, dat_a}, 32'h1280);
    chk("s1_addr1", addr_a, 0);
    wait_gap_a(n);
    chk("s1_gap", n, 967);
    chk("s1_wr2", {reg_a, dat_a}, 32'h1204);
    chk("s1_count1", cnt_a, 1);
    chk("s1_addr2", addr_a, 2);
    wait_done_a(n);
    chk("s1_done_lat", n, 5);
    chk("s1_count2", cnt_a, 2);
    tick(1);
    chk("s1_after_done", {busy_a, done_a}, 0);
    tick(1);
    chk("s1_done_once", done_cnt_a - d0, 1);
    // Back-pressure, ignored start and spurious done while issuing.
    rom_a[0] = 16'h1234; rom_a[1] = 16'h5678; rom_a[2] = 16'hFFFF;
    ready_a = 1'b0;
    pulse_a();
    wait_valid_a(n);
    chk("s2_latency", 1 + n, 3);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      start_a = (i == 10);
      spur_a  = (i == 20);
      tick(1);
      stable &= valid_a && busy_a && {reg_a, dat_a} == 16'h1234 && addr_a == 8'd0 && cnt_a == 9'd0;
    end
    start_a = 1'b0; spur_a = 1'b0;
    chk("s2_stall_stable", stable, 1);
    ready_a = 1'b1;
    wait_gap_a(n);
    chk("s2_wr2", {reg_a, dat_a}, 32'h5678);
    chk("s2_count1", cnt_a, 1);
    wait_done_a(n);
    chk("s2_count2", cnt_a, 2);
    tick(2);
    // Reset in the middle of a 200-cycle delay.
    rom_a[0] = 16'h1111; rom_a[1] = 16'hFF32; rom_a[2] = 16'h2222; rom_a[3] = 16'hFFFF;
    d0 = done_cnt_a;
    pulse_a();
    wait_valid_a(n);
    tick(105);
    chk("s3_in_delay", {busy_a, valid_a}, 2'b10);
    chk("s3_pre_count", cnt_a, 1);
    chk("s3_pre_addr", addr_a, 1);
    rst_n = 1'b0;
    #1;
    chk("s3_rst_outs", {busy_a, valid_a, done_a}, 0);
    chk("s3_rst_addr", addr_a, 0);
    chk("s3_rst_count", cnt_a, 0);
    chk("s3_rst_regdat", {reg_a, dat_a}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("s3_no_done", done_cnt_a - d0, 0);
    pulse_a();
    wait_valid_a(n);
    chk("s3_replay_lat", 1 + n, 3);
    chk("s3_replay_wr", {reg_a, dat_a}, 32'h1111);
    chk("s3_replay_addr", addr_a, 0);
    wait_done_a(n);
    chk("s3_done", done_a, 1);
    chk("s3_count", cnt_a, 2);
    tick(2);
    // Zero-length delay as first entry.
    rom_a[0] = 16'hFF00; rom_a[1] = 16'h3344; rom_a[2] = 16'hFFFF;
    pulse_a();
    wait_valid_a(n);
    chk("s4_latency", 1 + n, 5);
    chk("s4_wr", {reg_a, dat_a}, 32'h3344);
    chk("s4_addr", addr_a, 1);
    chk("s4_count0", cnt_a, 0);
    wait_done_a(n);
    chk("s4_count1", cnt_a, 1);
    // Small ROM without END marker stops at the last address.
    start_b = 1'b1; tick(1); start_b = 1'b0;
    n = 0;
    do begin tick(1); n++; end while (!done_b && n < 2000);
    chk("s5_done", done_b, 1);
    chk("s5_count", cnt_b, 8);
    chk("s5_addr", addr_b, 7);
    chk("s5_last_wr", {reg_b, dat_b}, 32'h0815);
    tick(2);
    chk("s5_no_wrap", wrap_b, 0);
    chk("s5_writes", wr_cnt_b, 8);
    chk("s5_done_once", done_cnt_b, 1);
    chk("s5_idle", busy_b, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cfg_seq.md
CFG_SEQ -- requirements
Module: cfg_seq

Interface
REQ-001 Parameter ADDR_W, default 8, width of ROM address.
REQ-002 Parameter REG_W, default 8, width of camera register address field.
REQ-003 Parameter DAT_W, default 8, width of camera register data field.
REQ-004 Parameter DELAY_UNIT, default 1000, clock cycles per delay tick.
REQ-005 Parameter MAX_ENTRIES, default 2**ADDR_W, hard sequence-length limit.
REQ-006 Port i_clk  in  1  sole clock; all logic rising-edge.
REQ-007 Port i_rstn  in  1  reset, asynchronous, active-low.
REQ-008 Port i_start  in  1  one-cycle pulse; begins sequence from address 0.
REQ-009 Port o_rom_addr  out  ADDR_W  ROM read address.
REQ-010 Port i_rom_data  in  REG_W+DAT_W  ROM word {reg, data}; valid exactly 1 cycle after o_rom_addr changes.
REQ-011 Port o_wr_valid  out  1  write request to SCCB master.
REQ-012 Port i_wr_ready  in  1  SCCB master accepts request when high with o_wr_valid.
REQ-013 Port o_wr_reg / o_wr_data  out  REG_W / DAT_W  register address / value of request.
REQ-014 Port i_wr_done  in  1  one-cycle pulse: accepted write finished on bus.
REQ-015 Port o_busy  out  1  high from accepted i_start until DONE.
REQ-016 Port o_done  out  1  one-cycle pulse at sequence end.
REQ-017 Port o_count  out  ADDR_W+1  number of register writes completed this run.

Function
REQ-018 States: IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY, DONE.
REQ-019 IDLE: on i_start, o_rom_addr<=0, o_count<=0, go FETCH; i_start ignored in every other state.
REQ-020 FETCH: wait one cycle for ROM latency, go DECODE.
REQ-021 DECODE: word all-ones (reg and data both all-ones) = END marker, go DONE.
REQ-022 DECODE: reg all-ones and data not all-ones = DELAY marker, load delay counter with data*DELAY_UNIT, go DELAY.
REQ-023 DECODE: any other word = register write, latch reg/data onto o_wr_reg/o_wr_data, go ISSUE.
REQ-024 ISSUE: o_wr_valid high, outputs stable; on i_wr_valid&&i_wr_ready deassert next cycle, go WAIT_DONE.
REQ-025 WAIT_DONE: on i_wr_done, o_count+1, advance address, go FETCH.
REQ-026 DELAY: decrement per cycle; at zero advance address, go FETCH; data=0 marker gives zero-cycle delay (advance immediately).
REQ-027 Address advance when o_rom_addr = MAX_ENTRIES-1 goes DONE (no wrap to 0).
REQ-028 DONE: o_done high one cycle, o_busy low next cycle, return IDLE.
REQ-029 i_wr_done outside WAIT_DONE ignored.
REQ-030 Delay counter width: ceil(log2((2**DAT_W-1)*DELAY_UNIT+1)) bits, no overflow.
REQ-031 Latency: start pulse to first o_wr_valid = 3 cycles (IDLE->FETCH->DECODE->ISSUE).

Reset
REQ-032 Reset asserted: state IDLE, o_rom_addr 0, o_wr_valid 0, o_wr_reg/o_wr_data 0, o_busy 0, o_done 0, o_count 0, delay counter 0.
REQ-033 Reset mid-write or mid-delay aborts immediately; no o_done; next run restarts at address 0.

Structure
REQ-034 Shared package cfg_pkg holds state encoding, END and DELAY marker constants, default parameter values.
REQ-035 One sub-module cfg_delay_timer (load, count, zero flag) is instantiated; ROM is external.

Verification
REQ-036 ROM {1280, FFF0 with DELAY_UNIT=4, 1204, FFFF}, i_wr_ready=1, i_wr_done 2 cycles after accept -> writes 12/80 then 12/04, 960-cycle gap between, o_done once, o_count=2.
REQ-037 i_wr_ready held low 50 cycles -> o_wr_valid stays high, o_wr_reg/o_wr_data unchanged, no address advance.
REQ-038 ROM with no END marker, ADDR_W=3 -> exactly 8 writes, o_done, o_rom_addr never wraps.
REQ-039 i_rstn low during DELAY with 100 cycles remaining -> all outputs reset values same cycle; later i_start replays from address 0.
REQ-040 i_start pulsed while busy and spurious i_wr_done in ISSUE -> no restart, no count change.
REQ-041 First entry FF00 -> zero delay, first write issued from address 1, o_count excludes marker.
